hazard_unit: RTL and testbench

Pipeline hazard unit for the five-stage processor. It produces the stall and flush signals that the pipeline controller consumes (StallF/StallD/StallE, FlushD/FlushE/FlushM) and the ALU operand forwarding selects. Its only sequential logic is a small FSM plus counter that holds a multi-cycle long-multiply in Execute. It sits beside the controller and datapath and takes register addresses and stage control bits from both.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_unit_if.sv | 35 +++
 rtl/long_op_sequencer.sv | 56 +++++
 rtl/hazard_unit.sv | 66 ++++++
 tb/tb_hazard_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   REG_W      : register address width
//   FWD_W      : forwarding select width
//   CNT_W      : long-op cycle counter width
//   FWD_RF/W/M : operand select codes (register file / ResultW / ALUResultM)
//   state_e    : long-op sequencer states
//   fwd_sel    : forwarding priority rule for one Execute operand
package hazard_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_W_SEL = 2'b01;
    localparam logic [FWD_W-1:0] FWD_M = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Memory stage wins over Writeback since it holds the younger result.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic             reg_write_m,
        input logic [REG_W-1:0] wa3_m,
        input logic             reg_write_w,
        input logic [REG_W-1:0] wa3_w,
        input logic [REG_W-1:0] ra_e
    );
        if (reg_write_m && (wa3_m == ra_e)) begin
            return FWD_M;
        end else if (reg_write_w && (wa3_w == ra_e)) begin
            return FWD_W_SEL;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit bundle: register addresses and stage control bits from the
// controller/datapath, stall/flush/forward controls back to them.
//   slave  : the hazard unit (consumes stage info, drives controls)
//   master : the pipeline side (drives stage info, consumes controls)
interface hazard_unit_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E;
    logic [REG_W-1:0] WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemToRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             BranchTakenE;
    logic             LongE;
    logic [FWD_W-1:0] ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM
    );

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM
    );

endinterface

// File: rtl/long_op_sequencer.sv
// Holds a multi-cycle long operation in Execute for LONG_CYCLES cycles.
//   clk, reset : pipeline clock, async active-high reset
//   LongE      : instruction in Execute is a long operation
//   Busy       : combinational; 1 while Execute must be held
module long_op_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic LongE,
    output logic Busy
);

    localparam bit LONG_EN = (LONG_CYCLES > 1);
    // First cycle is spent in IDLE, the last (cnt==0) releases the stall.
    localparam logic [CNT_W-1:0] CNT_LOAD = LONG_EN ? CNT_W'(LONG_CYCLES - 2) : '0;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // State and remaining-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LongE && LONG_EN) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Zero-latency hold: asserted in the same cycle LongE first appears.
    always_comb begin
        Busy = 1'b0;
        case (state_q)
            IDLE: Busy = LongE && LONG_EN;
            BUSY: Busy = (cnt_q != '0);
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush controls and ALU operand forwarding.
//   clk, reset : pipeline clock, async active-high reset
//   hz         : hazard_unit_if.slave bundle (stage info in, controls out)
// Config macro HAZARD_FORWARD_EN: when defined, operands forward from M/W and
// only load-use stalls; otherwise forwarding is off and every RAW hazard
// against E or M stalls.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

    logic busy_c;
    logic data_stall_c;
    logic pc_pend_c;

    long_op_sequencer #(
        .LONG_CYCLES (LONG_CYCLES)
    ) u_seq (
        .clk   (clk),
        .reset (reset),
        .LongE (hz.LongE),
        .Busy  (busy_c)
    );

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers everything except a load result not yet read.
    assign hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA1E);
    assign hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA2E);
    assign data_stall_c = hz.MemToRegE && hz.RegWriteE &&
                          ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
`else
    // No bypass: wait for E and M writers; W is covered by split-phase RF.
    logic unused_fwd_c;
    assign unused_fwd_c = ^{hz.RA1E, hz.RA2E, hz.WA3W, hz.RegWriteW, hz.MemToRegE};
    assign hz.ForwardAE = FWD_RF;
    assign hz.ForwardBE = FWD_RF;
    assign data_stall_c = (hz.RegWriteE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E))) ||
                          (hz.RegWriteM && ((hz.RA1D == hz.WA3M) || (hz.RA2D == hz.WA3M)));
`endif

    assign pc_pend_c = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;

    // Long-op hold overrides all other controls and bubbles M behind it.
    always_comb begin
        hz.StallF = data_stall_c || pc_pend_c;
        hz.StallD = data_stall_c;
        hz.StallE = 1'b0;
        hz.FlushD = pc_pend_c || hz.PCSrcW || hz.BranchTakenE;
        hz.FlushE = data_stall_c || hz.BranchTakenE;
        hz.FlushM = 1'b0;
        if (busy_c) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushD = 1'b0;
            hz.FlushE = 1'b0;
            hz.FlushM = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: two instances (LONG_CYCLES=4 and 1)
// share one stimulus stream and are compared against a behavioural model.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rw_e, rw_m, rw_w, mtr_e, pc_d, pc_e, pc_m, pc_w, br_e, long_e;

    int n_checks = 0;
    int n_fail   = 0;
    int occ4     = 0;
    int occ1     = 0;

`ifdef HAZARD_FORWARD_EN
    localparam logic [1:0] EXP_FWD_M     = 2'b10;
    localparam logic [1:0] EXP_FWD_W     = 2'b01;
    localparam bit         EXP_RAW_STALL = 1'b0;
`else
    localparam logic [1:0] EXP_FWD_M     = 2'b00;
    localparam logic [1:0] EXP_FWD_W     = 2'b00;
    localparam bit         EXP_RAW_STALL = 1'b1;
`endif

    hazard_unit_if hz4 ();
    hazard_unit_if hz1 ();

    hazard_unit #(.LONG_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .hz(hz4.slave));
    hazard_unit #(.LONG_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .hz(hz1.slave));

    always_comb begin
        hz4.RA1D = ra1d;  hz1.RA1D = ra1d;
        hz4.RA2D = ra2d;  hz1.RA2D = ra2d;
        hz4.RA1E = ra1e;  hz1.RA1E = ra1e;
        hz4.RA2E = ra2e;  hz1.RA2E = ra2e;
        hz4.WA3E = wa3e;  hz1.WA3E = wa3e;
        hz4.WA3M = wa3m;  hz1.WA3M = wa3m;
        hz4.WA3W = wa3w;  hz1.WA3W = wa3w;
        hz4.RegWriteE = rw_e;  hz1.RegWriteE = rw_e;
        hz4.RegWriteM = rw_m;  hz1.RegWriteM = rw_m;
        hz4.RegWriteW = rw_w;  hz1.RegWriteW = rw_w;
        hz4.MemToRegE = mtr_e; hz1.MemToRegE = mtr_e;
        hz4.PCSrcD = pc_d;  hz1.PCSrcD = pc_d;
        hz4.PCSrcE = pc_e;  hz1.PCSrcE = pc_e;
        hz4.PCSrcM = pc_m;  hz1.PCSrcM = pc_m;
        hz4.PCSrcW = pc_w;  hz1.PCSrcW = pc_w;
        hz4.BranchTakenE = br_e; hz1.BranchTakenE = br_e;
        hz4.LongE = long_e; hz1.LongE = long_e;
    end

    // Packed view: {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    logic [9:0] out4, out1;
    assign out4 = {hz4.ForwardAE, hz4.ForwardBE, hz4.StallF, hz4.StallD, hz4.StallE,
                   hz4.FlushD, hz4.FlushE, hz4.FlushM};
    assign out1 = {hz1.ForwardAE, hz1.ForwardBE, hz1.StallF, hz1.StallD, hz1.StallE,
                   hz1.FlushD, hz1.FlushE, hz1.FlushM};

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // occ = cycles the current long instruction has already spent in E.
    function automatic int age_of(input int occ, input bit longe);
        if (occ > 0) return occ + 1;
        if (longe) return 1;
        return 0;
    endfunction

    function automatic bit model_busy(input int occ, input int cycles, input bit longe);
        int age;
        age = age_of(occ, longe);
        return (age != 0) && (age < cycles);
    endfunction

    function automatic int next_occ(input int occ, input int cycles, input bit longe);
        if (model_busy(occ, cycles, longe)) return age_of(occ, longe);
        return 0;
    endfunction

    function automatic logic [9:0] model_vec(input bit busy);
        logic [1:0] fa, fb;
        bit dstall, pcpend;
        fa = 2'b00;
        fb = 2'b00;
`ifdef HAZARD_FORWARD_EN
        if (rw_m && wa3m == ra1e) fa = 2'b10; else if (rw_w && wa3w == ra1e) fa = 2'b01;
        if (rw_m && wa3m == ra2e) fb = 2'b10; else if (rw_w && wa3w == ra2e) fb = 2'b01;
        dstall = mtr_e && rw_e && (ra1d == wa3e || ra2d == wa3e);
`else
        dstall = (rw_e && (ra1d == wa3e || ra2d == wa3e)) ||
                 (rw_m && (ra1d == wa3m || ra2d == wa3m));
`endif
        pcpend = pc_d || pc_e || pc_m;
        if (busy) return {fa, fb, 6'b111_001};
        return {fa, fb, dstall || pcpend, dstall, 1'b0,
                pcpend || pc_w || br_e, dstall || br_e, 1'b0};
    endfunction

    // Check both instances against the model, then advance one clock.
    task automatic step(input string tag);
        if (reset) begin
            occ4 = 0;
            occ1 = 0;
        end
        #1;
        chk({tag, "/L4"}, out4, model_vec(model_busy(occ4, 4, long_e)));
        chk({tag, "/L1"}, out1, model_vec(model_busy(occ1, 1, long_e)));
        @(posedge clk);
        if (reset) begin
            occ4 = 0;
            occ1 = 0;
        end else begin
            occ4 = next_occ(occ4, 4, long_e);
            occ1 = next_occ(occ1, 1, long_e);
        end
        #1;
    endtask

    task automatic clear_inputs();
        {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = '0;
        {rw_e, rw_m, rw_w, mtr_e, pc_d, pc_e, pc_m, pc_w, br_e, long_e} = '0;
    endtask

    logic [3:0] hold_exp [4];

    initial begin
        hold_exp[0] = 4'b1111; hold_exp[1] = 4'b1111;
        hold_exp[2] = 4'b1111; hold_exp[3] = 4'b0000;

        // Reset state
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("reset_L4", out4, 10'd0);
        chk("reset_L1", out1, 10'd0);
        step("reset");
        reset = 1'b0;
        step("idle");

        // Forwarding: M has priority over W
        rw_m = 1'b1; wa3m = 4'd5; ra1e = 4'd5; rw_w = 1'b1; wa3w = 4'd5;
        #1 chk("fwdA_M", 10'(hz4.ForwardAE), 10'(EXP_FWD_M));
        step("fwd_m");
        rw_m = 1'b0;
        #1 chk("fwdA_W", 10'(hz4.ForwardAE), 10'(EXP_FWD_W));
        step("fwd_w");
        clear_inputs();

        // Load-use hazard on operand B of Decode
        mtr_e = 1'b1; rw_e = 1'b1; wa3e = 4'd3; ra2d = 4'd3; ra1d = 4'd7;
        #1 chk("ld_stall", 10'({hz4.StallF, hz4.StallD, hz4.FlushE, hz4.FlushD}), 10'(4'b1110));
        step("ld_use");
        mtr_e = 1'b0;
        #1 chk("raw_stall", 10'({hz4.StallF, hz4.StallD, hz4.FlushE}), 10'({3{EXP_RAW_STALL}}));
        step("raw");
        clear_inputs();

        // PC write moving D -> E -> M -> W
        for (int i = 0; i < 4; i++) begin
            pc_d = (i == 0); pc_e = (i == 1); pc_m = (i == 2); pc_w = (i == 3);
            #1 chk($sformatf("pc_stallF_%0d", i), 10'(hz4.StallF), 10'(i < 3));
            chk($sformatf("pc_flushD_%0d", i), 10'(hz4.FlushD), 10'(1));
            step("pcsrc");
        end
        clear_inputs();
        br_e = 1'b1;
        #1 chk("branch", 10'({hz4.FlushD, hz4.FlushE, hz4.StallF}), 10'(3'b110));
        step("branch");
        clear_inputs();

        // Long op held 4 cycles, then two back-to-back long ops
        long_e = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1 chk($sformatf("long4_%0d", i),
                   10'({hz4.StallF, hz4.StallD, hz4.StallE, hz4.FlushM}), 10'(hold_exp[i % 4]));
            chk($sformatf("long1_%0d", i), out1, 10'd0);
            step("long");
        end
        clear_inputs();
        step("gap");

        // Asynchronous reset in the 2nd busy cycle, then full restart
        long_e = 1'b1;
        step("pre_rst");
        clear_inputs();
        reset = 1'b1;
        #1 chk("rst_mid_busy", out4, 10'd0);
        step("rst_mid");
        reset = 1'b0;
        long_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("restart_%0d", i),
                   10'({hz4.StallF, hz4.StallD, hz4.StallE, hz4.FlushM}), 10'(hold_exp[i]));
            step("restart");
        end
        clear_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra1d = 4'($urandom_range(0, 3)); ra2d = 4'($urandom_range(0, 3));
            ra1e = 4'($urandom_range(0, 3)); ra2e = 4'($urandom_range(0, 3));
            wa3e = 4'($urandom_range(0, 3)); wa3m = 4'($urandom_range(0, 3));
            wa3w = 4'($urandom_range(0, 3));
            rw_e = ($urandom_range(0, 1) == 0); rw_m = ($urandom_range(0, 1) == 0);
            rw_w = ($urandom_range(0, 1) == 0); mtr_e = ($urandom_range(0, 2) == 0);
            pc_d = ($urandom_range(0, 5) == 0); pc_e = ($urandom_range(0, 5) == 0);
            pc_m = ($urandom_range(0, 5) == 0); pc_w = ($urandom_range(0, 5) == 0);
            br_e = ($urandom_range(0, 5) == 0); long_e = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
